mdr_bus_if: RTL

- Parametrised memory data register with its own memory handshake and timeout.
- Keeps the existing direct-load path from the internal bus, so the CPU can load the register straight from BusMuxOut.
- Adds request/acknowledge memory reads and writes, with a timeout for an acknowledge that never arrives.
- Adds byte, half and word access with lane steering, byte enables and optional sign extension.
- Sits between the datapath bus (BusMuxOut/BusMuxIn) and the memory port, driven by the control unit.

---
 rtl/cpu_mem_pkg.sv | 37 +++
 rtl/mdr_load_fmt.sv | 52 +++++
 rtl/mdr_bus_if.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the memory data register and its memory port.
package cpu_mem_pkg;

  // Handshake states of the memory data register
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR_WAIT = 2'b10
  } mdr_state_t;

  // Access size encodings as presented on the size input
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  // Returns whether byte lane 'lane' is enabled for an access of the given
  // size at byte offset 'offset' on a bus that is 'nbytes' lanes wide.
  // The offset is aligned down to the access size, so misaligned low bits
  // are simply dropped.
  function automatic logic lane_enable(input logic [1:0] size,
                                       input int offset,
                                       input int lane,
                                       input int nbytes);
    int span;
    int base;
    case (size)
      SZ_BYTE: span = 1;
      SZ_HALF: span = 2;
      SZ_WORD: span = 4;
      default: span = nbytes;
    endcase
    base = offset & ~(span - 1);
    return (lane >= base) && (lane < base + span);
  endfunction

endpackage

// File: rtl/mdr_load_fmt.sv
// Read-data formatter: picks the addressed lane of the memory word, moves it
// down to bit 0 and fills the upper bits with zeros or the lane's sign bit.
module mdr_load_fmt
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [LANE_W-1:0]     addr_lo,
  output logic [DATA_WIDTH-1:0] fmt_data
);

  logic [LANE_W-1:0]     aligned;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  fill;

  // Align the offset, shift the lane down, then build the extended result
  always_comb begin
    aligned  = addr_lo;
    shifted  = '0;
    fill     = 1'b0;
    fmt_data = rdata;
    case (size)
      SZ_HALF: aligned[0]   = 1'b0;
      SZ_WORD: aligned[1:0] = 2'b00;
      default: aligned      = addr_lo;
    endcase
    shifted = rdata >> {aligned, 3'b000};
    case (size)
      SZ_BYTE: begin
        fill          = sign_ext & shifted[7];
        fmt_data      = {DATA_WIDTH{fill}};
        fmt_data[7:0] = shifted[7:0];
      end
      SZ_HALF: begin
        fill           = sign_ext & shifted[15];
        fmt_data       = {DATA_WIDTH{fill}};
        fmt_data[15:0] = shifted[15:0];
      end
      SZ_WORD: begin
        fill           = sign_ext & shifted[31];
        fmt_data       = {DATA_WIDTH{fill}};
        fmt_data[31:0] = shifted[31:0];
      end
      default: fmt_data = rdata;
    endcase
  end

endmodule

// File: rtl/mdr_bus_if.sv
// Memory data register with direct bus load plus a request/acknowledge
// memory port, per-access byte enables, lane steering and an ack timeout.
module mdr_bus_if
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    MDRin,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [LANE_W-1:0]       addr_lo,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  input  logic [DATA_WIDTH-1:0]   Mdatain,
  input  logic                    mem_ack,
  output logic                    mem_rd_req,
  output logic                    mem_wr_req,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   Mdataout,
  output logic [DATA_WIDTH-1:0]   BusMuxIn,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mdr_state_t            state;
  logic [DATA_WIDTH-1:0] mdr_reg;
  logic [CNT_W-1:0]      wait_cnt;
  logic [1:0]            lat_size;
  logic                  lat_sign;
  logic [LANE_W-1:0]     lat_addr;
  logic [NB-1:0]         access_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] fmt_data;

  assign BusMuxIn = mdr_reg;

  // Read data is formatted with the fields latched when the read started
  mdr_load_fmt #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANE_W    (LANE_W)
  ) u_fmt (
    .rdata   (Mdatain),
    .size    (lat_size),
    .sign_ext(lat_sign),
    .addr_lo (lat_addr),
    .fmt_data(fmt_data)
  );

  // Byte enables for the access being requested this cycle
  always_comb begin
    access_be = '0;
    for (int i = 0; i < NB; i++) begin
      access_be[i] = lane_enable(size, int'(addr_lo), i, NB);
    end
  end

  // Write data: low bits of the register replicated across every lane
  always_comb begin
    wr_data = mdr_reg;
    case (size)
      SZ_BYTE: wr_data = {NB{mdr_reg[7:0]}};
      SZ_HALF: wr_data = {(DATA_WIDTH / 16){mdr_reg[15:0]}};
      SZ_WORD: wr_data = {(DATA_WIDTH / 32){mdr_reg[31:0]}};
      default: wr_data = mdr_reg;
    endcase
  end

  // Handshake FSM; every output is registered and an ack beats the timeout
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      mdr_reg    <= '0;
      wait_cnt   <= '0;
      lat_size   <= SZ_BYTE;
      lat_sign   <= 1'b0;
      lat_addr   <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_be     <= '0;
      Mdataout   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Read) begin
            lat_size   <= size;
            lat_sign   <= sign_ext;
            lat_addr   <= addr_lo;
            wait_cnt   <= '0;
            timeout    <= 1'b0;
            mem_rd_req <= 1'b1;
            mem_be     <= access_be;
            busy       <= 1'b1;
            state      <= RD_WAIT;
          end else if (Write) begin
            lat_size   <= size;
            lat_sign   <= sign_ext;
            lat_addr   <= addr_lo;
            wait_cnt   <= '0;
            timeout    <= 1'b0;
            mem_wr_req <= 1'b1;
            mem_be     <= access_be;
            Mdataout   <= wr_data;
            busy       <= 1'b1;
            state      <= WR_WAIT;
          end else if (MDRin) begin
            mdr_reg <= BusMuxOut;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack || (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            if (mem_ack && (state == RD_WAIT)) begin
              mdr_reg <= fmt_data;
            end
            if (!mem_ack) begin
              timeout <= 1'b1;
            end
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_be     <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          mem_rd_req <= 1'b0;
          mem_wr_req <= 1'b0;
          mem_be     <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
